// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regdump_pkg
// Purpose  : Shared types and constants for the register-file dump reader.
//            Holds the dump FSM state encoding, the default frame header
//            byte, the default bytes-per-word count and a counter-width
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package regdump_pkg;

  // Dump sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_HDR  = 3'd2,
    S_LOAD = 3'd3,
    S_SEND = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         DATA_WIDTH_DEF = 32;
  localparam int         BYTES_PER_WORD = DATA_WIDTH_DEF / 8;

  // Counter width that never collapses to zero bits, so a one-entry
  // range still gets a real (always-zero) register.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader_if
// Purpose  : Bundles the dump reader's control handshake, register-file
//            read port and byte stream.
// Ports    : start/busy/done        - dump request and status
//            halt_req/halt_ack      - core halt handshake
//            rd_addr/rd_data        - asynchronous register-file read port
//            tx_data/tx_valid/tx_ready - valid/ready byte stream
//            modport master = dump reader side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_dump_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  halt_req;
  logic                  halt_ack;
  logic [4:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, halt_ack, rd_data, tx_ready,
    output halt_req, rd_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, halt_ack, rd_data, tx_ready,
    input  halt_req, rd_addr, tx_data, tx_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader_serializer.sv
`default_nettype none
// ============================================================================
// Module   : word_byte_serializer
// Purpose  : Holds one register word, presents it LSB byte first, shifts one
//            byte per accepted transfer, flags the final byte of the word and
//            accumulates an XOR checksum over every byte shifted out.
// Ports    : clk, reset_n        - clock, async active-low reset
//            load, word          - capture a new word (byte counter restarts)
//            shift               - current byte accepted downstream
//            clear_csum          - restart the checksum for a new frame
//            byte_out, last, csum - current byte, last-byte flag, checksum
// Revision : 1.0 - initial release
// ============================================================================
module word_byte_serializer
  import regdump_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  clear_csum,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [7:0]            byte_out,
  output logic                  last,
  output logic [7:0]            csum
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = cnt_width(NB);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]            csum_q, csum_d;

  assign byte_out = shreg_q[7:0];
  assign last     = (byte_cnt_q == CW'(NB - 1));
  assign csum     = csum_q;

  always_comb begin
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    if (clear_csum) begin
      csum_d = '0;
    end
    if (load) begin
      shreg_d    = word;
      byte_cnt_d = '0;
    end else if (shift) begin
      shreg_d    = shreg_q >> 8;
      csum_d     = csum_q ^ shreg_q[7:0];
      // Wrap on the last byte so the counter is clean for the next word.
      byte_cnt_d = last ? '0 : byte_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
    end else begin
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Debug read-back engine. On start it halts the core, reads
//            x0..x(NUM_REGS-1) through the shared asynchronous read port and
//            streams a frame: SYNC_BYTE, every word LSB byte first, then the
//            XOR of all data bytes.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            bus      - regfile_dump_reader_if.master (start/busy/done,
//                       halt handshake, read port, byte stream)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int         NUM_REGS   = 32,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regfile_dump_reader_if.master  bus
);

  localparam int IW = cnt_width(NUM_REGS);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic       ser_load;
  logic       ser_shift;
  logic       ser_clear;
  logic [7:0] ser_byte;
  logic       ser_last;
  logic [7:0] ser_csum;

  word_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (ser_load),
    .shift      (ser_shift),
    .clear_csum (ser_clear),
    .word       (bus.rd_data),
    .byte_out   (ser_byte),
    .last       (ser_last),
    .csum       (ser_csum)
  );

  // Next-state and output decode. Every output depends only on state and
  // registers, so nothing from the inputs reaches the outputs in one cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    ser_clear    = 1'b0;
    bus.halt_req = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rd_addr  = 5'd0;

    unique case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        bus.halt_req = 1'b1;
        if (bus.halt_ack) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        bus.halt_req = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = SYNC_BYTE;
        if (bus.tx_ready) begin
          idx_d     = '0;
          ser_clear = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        // One cycle for the asynchronous read to settle before capture.
        bus.halt_req = 1'b1;
        bus.rd_addr  = 5'(idx_q);
        ser_load     = 1'b1;
        state_d      = S_SEND;
      end
      S_SEND: begin
        bus.halt_req = 1'b1;
        bus.rd_addr  = 5'(idx_q);
        bus.tx_valid = 1'b1;
        bus.tx_data  = ser_byte;
        if (bus.tx_ready) begin
          ser_shift = 1'b1;
          if (ser_last) begin
            if (idx_q == IW'(NUM_REGS - 1)) begin
              state_d = S_CSUM;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_CSUM: begin
        bus.halt_req = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = ser_csum;
        if (bus.tx_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Halt is released in the same cycle the completion pulse fires.
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Purpose  : Self-checking bench for regfile_dump_reader. A table of frame
//            scenarios (register pattern, stream readiness, expected length,
//            checksum, last word and completion cycle) plus hand-written
//            sequences for halt-ack delay, start during a dump and
//            asynchronous reset mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;
  import regdump_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_dump_reader_if #(.DATA_WIDTH(32)) bus ();

  regfile_dump_reader #(
    .DATA_WIDTH (32),
    .NUM_REGS   (32),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register-file model with an asynchronous read port
  logic [31:0] regs [32];
  assign bus.rd_data = regs[bus.rd_addr];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_pct = 100;
  int done_cnt = 0;
  int done_at = 0;
  int stab_viol = 0;
  logic [7:0] got [$];
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream ready is changed well after the edge so it is stable at negedge.
  always @(posedge clk) begin
    #2;
    bus.tx_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
  end

  // Monitor: record accepted bytes, done pulses and stability violations.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pv && !pr && (!bus.tx_valid || bus.tx_data != pd)) stab_viol++;
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
      if (bus.done) begin
        done_cnt++;
        done_at = cyc - start_cyc + 1;
      end
    end
    pv = bus.tx_valid;
    pr = bus.tx_ready;
    pd = bus.tx_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_regs(input int pattern);
    for (int i = 0; i < 32; i++) begin
      case (pattern)
        0:       regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
        1:       regs[i] = (i == 31) ? 32'hFFFF_FFFF : 32'h0;
        default: regs[i] = 32'h0;
      endcase
    end
  endtask

  task automatic clear_obs();
    got.delete();
    done_cnt  = 0;
    done_at   = 0;
    stab_viol = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_send_reg(input int r, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.rd_addr == 5'(r)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference frame built from the register model; counts byte mismatches.
  function automatic int frame_errors();
    logic [7:0] exp [$];
    logic [7:0] cs;
    int e;
    cs = 8'h00;
    exp.push_back(8'hA5);
    for (int i = 0; i < 32; i++) begin
      for (int b = 0; b < 4; b++) begin
        exp.push_back(regs[i][8*b +: 8]);
        cs ^= regs[i][8*b +: 8];
      end
    end
    exp.push_back(cs);
    e = 0;
    if (got.size() != exp.size()) return 999;
    for (int k = 0; k < exp.size(); k++) if (got[k] != exp[k]) e++;
    return e;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] exp_csum,
                             input logic [31:0] exp_last, input int exp_cycles);
    logic [31:0] last_word;
    last_word = (got.size() == 130) ? {got[125], got[126], got[127], got[128]} : 32'hDEAD_BEEF;
    check({tag, " len"}, 32'(got.size()), 32'd130);
    check({tag, " hdr"}, (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'hA5);
    check({tag, " bytes"}, 32'(frame_errors()), 32'd0);
    check({tag, " csum"}, (got.size() == 130) ? 32'(got[129]) : 32'hFFFF, 32'(exp_csum));
    check({tag, " last_word"}, last_word, exp_last);
    check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, " stable"}, 32'(stab_viol), 32'd0);
    if (exp_cycles != 0) check({tag, " done_cycle"}, 32'(done_at), 32'(exp_cycles));
  endtask

  typedef struct {
    int          pattern;
    int          ready_pct;
    logic [7:0]  exp_csum;
    logic [31:0] exp_last;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit ok;
    int viol;

    vecs[0] = '{pattern: 0, ready_pct: 100, exp_csum: 8'h10, exp_last: 32'h1F00_0010, exp_cycles: 164};
    vecs[1] = '{pattern: 0, ready_pct: 30,  exp_csum: 8'h10, exp_last: 32'h1F00_0010, exp_cycles: 0};
    vecs[2] = '{pattern: 1, ready_pct: 100, exp_csum: 8'h00, exp_last: 32'hFFFF_FFFF, exp_cycles: 164};
    vecs[3] = '{pattern: 2, ready_pct: 100, exp_csum: 8'h00, exp_last: 32'h0000_0000, exp_cycles: 164};

    bus.start    = 1'b0;
    bus.halt_ack = 1'b1;
    bus.tx_ready = 1'b1;
    set_regs(0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst halt_req", 32'(bus.halt_req), 32'd0);
    check("rst tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst tx_data", 32'(bus.tx_data), 32'd0);
    check("rst rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frame scenarios
    for (int v = 0; v < 4; v++) begin
      set_regs(vecs[v].pattern);
      ready_pct = vecs[v].ready_pct;
      clear_obs();
      pulse_start();
      wait_done(3000, ok);
      check($sformatf("vec%0d done_seen", v), 32'(ok), 32'd1);
      repeat (5) @(negedge clk);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_csum, vecs[v].exp_last, vecs[v].exp_cycles);
      ready_pct = 100;
    end

    // Halt acknowledge delayed by 20 cycles
    set_regs(0);
    clear_obs();
    bus.halt_ack = 1'b0;
    pulse_start();
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.halt_req || !bus.busy || bus.tx_valid || got.size() != 0) viol++;
    end
    check("halt_wait hold", 32'(viol), 32'd0);
    @(posedge clk); #2 bus.halt_ack = 1'b1;
    @(negedge clk);
    check("halt_wait pre_hdr_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    check("halt_wait hdr_valid", 32'(bus.tx_valid), 32'd1);
    check("halt_wait hdr_data", 32'(bus.tx_data), 32'hA5);
    wait_done(3000, ok);
    check("halt_wait done_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    check_frame("halt_wait", 8'h10, 32'h1F00_0010, 0);

    // Start pulsed again while register 5 is being sent
    clear_obs();
    pulse_start();
    wait_send_reg(5, 2000, ok);
    check("restart reached_r5", 32'(ok), 32'd1);
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    wait_done(3000, ok);
    check("restart done_seen", 32'(ok), 32'd1);
    repeat (30) @(negedge clk);
    check("restart busy_after", 32'(bus.busy), 32'd0);
    check_frame("restart", 8'h10, 32'h1F00_0010, 0);

    // Asynchronous reset while register 10 is being sent
    clear_obs();
    pulse_start();
    wait_send_reg(10, 2000, ok);
    check("areset reached_r10", 32'(ok), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("areset tx_valid", 32'(bus.tx_valid), 32'd0);
    check("areset halt_req", 32'(bus.halt_req), 32'd0);
    check("areset busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("areset no_done", 32'(done_cnt), 32'd0);
    clear_obs();
    pulse_start();
    wait_done(3000, ok);
    check("areset2 done_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    check_frame("areset2", 8'h10, 32'h1F00_0010, 164);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
